// File: rtl/wddr_axi_ctr.sv
// wddr_axi_ctr: single-burst AXI4 write master fed by a valid/ready word stream.
module wddr_axi_ctr #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk_sys,
  input  logic                      rst_sys,
  input  logic                      wr_start,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [8:0]                wr_len,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_data_vld,
  output logic                      wr_data_rdy,
  output logic                      wr_busy,
  output logic                      wr_done,
  output logic                      wr_err,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awlock,
  output logic [3:0]                m_axi_awcache,
  output logic [2:0]                m_axi_awprot,
  output logic [3:0]                m_axi_awqos,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready
);
  typedef enum logic [2:0] {IDLE, AW, W, B, ERR} state_t;
  state_t     state;
  logic       start_dly;
  logic [7:0] cnt;
  logic       start_edge;
  logic       beat;
  assign start_edge    = wr_start & ~start_dly;
  assign beat          = m_axi_wvalid & m_axi_wready;
  assign m_axi_awsize  = 3'd2;
  assign m_axi_awburst = 2'd1;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd3;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_wstrb   = '1;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wvalid  = (state == W) & wr_data_vld;
  assign wr_data_rdy   = (state == W) & m_axi_wready;
  assign m_axi_wlast   = (state == W) & (cnt == m_axi_awlen);
  assign m_axi_bready  = (state == B);
  assign wr_busy       = (state != IDLE) | wr_done;
  // The done pulse after B is still part of the busy window, so edges there are dropped.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state         <= IDLE;
      start_dly     <= 1'b0;
      cnt           <= 8'd0;
      wr_done       <= 1'b0;
      wr_err        <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= 8'd0;
      m_axi_awvalid <= 1'b0;
    end else begin
      start_dly <= wr_start;
      wr_done   <= 1'b0;
      wr_err    <= 1'b0;
      case (state)
        IDLE: if (start_edge && !wr_done) begin
          if (wr_len != 9'd0 && wr_len <= 9'd256) begin
            state         <= AW;
            m_axi_awaddr  <= wr_addr;
            m_axi_awlen   <= wr_len[7:0] - 8'd1;
            m_axi_awvalid <= 1'b1;
          end else begin
            state   <= ERR;
            wr_done <= 1'b1;
            wr_err  <= 1'b1;
          end
        end
        AW: if (m_axi_awready) begin
          m_axi_awvalid <= 1'b0;
          state         <= W;
        end
        W: if (beat) begin
          cnt   <= m_axi_wlast ? 8'd0 : cnt + 8'd1;
          state <= m_axi_wlast ? B : W;
        end
        B: if (m_axi_bvalid) begin
          state   <= IDLE;
          wr_done <= 1'b1;
          wr_err  <= m_axi_bresp[1];
        end
        ERR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wddr_axi_ctr.sv
// tb_wddr_axi_ctr: vector table plus randomized bursts checked against a queue-based burst model.
module tb_wddr_axi_ctr;
  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b1;
  logic        wr_start = 1'b0;
  logic [63:0] wr_addr = '0;
  logic [8:0]  wr_len = '0;
  logic [31:0] wr_data = '0;
  logic        wr_data_vld = 1'b0;
  logic        wr_data_rdy, wr_busy, wr_done, wr_err;
  logic [63:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize, m_axi_awprot;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache, m_axi_awqos, m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wlast, m_axi_wvalid, m_axi_bready;
  logic        m_axi_awready = 1'b0;
  logic        m_axi_wready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  wddr_axi_ctr dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_data(wr_data), .wr_data_vld(wr_data_vld), .wr_data_rdy(wr_data_rdy), .wr_busy(wr_busy),
    .wr_done(wr_done), .wr_err(wr_err), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [63:0] addr;
    logic [8:0]  len;
    logic [1:0]  bresp;
    int          aw_dly;
    bit          rnd;
    bit          poke;
    int          rst_at;
    bit          exp_err;
    int          exp_beats;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_txn(input vec_t v);
    bit legal = (v.len != 0) && (v.len <= 256);
    int nbeats = 0, aw_hs = 0, aw_cnt = 0, b_k = -10, src_i = 0;
    bit aw_done = 0, w_done = 0, b_done = 0, b_pend = 0, got_done = 0, poked = 0, in_w, in_b;
    logic [31:0] q[$];
    logic [31:0] src[$];
    if (legal)
      for (int i = 0; i < int'(v.len); i++) begin
        src.push_back($urandom);
        q.push_back(src[i]);
      end
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk_sys);
      if (v.rst_at >= 0 && nbeats == v.rst_at && k > 0) begin
        rst_sys = 1'b1;
        wr_data_vld = 1'b0;
        #1;
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_wvalid", m_axi_wvalid, 0);
        chk("rst_wlast", m_axi_wlast, 0);
        chk("rst_bready", m_axi_bready, 0);
        chk("rst_busy", wr_busy, 0);
        chk("rst_awaddr", m_axi_awaddr, 0);
        repeat (3) begin
          @(negedge clk_sys);
          chk("rst_no_done", wr_done, 0);
        end
        rst_sys = 1'b0;
        break;
      end
      wr_start = (k == 0) || (v.poke && nbeats == 3 && !poked);
      if (wr_start) begin
        wr_addr = (k == 0) ? v.addr : v.addr + 64'h100;
        wr_len  = (k == 0) ? v.len : 9'd1;
        if (k != 0) poked = 1;
      end
      m_axi_awready = (aw_cnt >= v.aw_dly);
      m_axi_wready  = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data_vld   = (src_i < src.size()) && (v.rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      wr_data       = (src_i < src.size()) ? src[src_i] : 32'h0;
      m_axi_bvalid  = b_pend && (v.rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      m_axi_bresp   = v.bresp;
      #1;
      in_w = aw_done && !w_done;
      in_b = w_done && !b_done;
      if (k == 0) begin
        chk("idle_busy", wr_busy, 0);
        chk("idle_awvalid", m_axi_awvalid, 0);
      end
      if (k == 1 && legal) chk("aw_latency", m_axi_awvalid, 1);
      if (k == 1 && !legal) begin
        chk("err_done", wr_done, 1);
        chk("err_flag", wr_err, 1);
      end
      if (k >= 1) chk("busy", wr_busy, 1);
      if (!legal) chk("err_no_aw", m_axi_awvalid, 0);
      chk("wvalid_gate", m_axi_wvalid, in_w && wr_data_vld);
      chk("rdy_gate", wr_data_rdy, in_w && m_axi_wready);
      chk("wlast", m_axi_wlast, in_w && nbeats == int'(v.len) - 1);
      chk("bready", m_axi_bready, in_b);
      if (m_axi_awvalid) begin
        chk("awaddr", m_axi_awaddr, v.addr);
        chk("awlen", m_axi_awlen, 64'(v.len - 9'd1));
        if (m_axi_awready) aw_hs++;
        else aw_cnt++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (q.size() == 0) chk("extra_beat", 1, 0);
        else chk("wdata", m_axi_wdata, q.pop_front());
        nbeats++;
        if (m_axi_wlast) begin
          w_done = 1;
          b_pend = 1;
        end
      end
      if (wr_data_vld && wr_data_rdy) src_i++;
      if (m_axi_bready && m_axi_bvalid) begin
        b_done = 1;
        b_pend = 0;
        b_k = k;
      end
      if (wr_done) begin
        chk("done_err", wr_err, v.exp_err);
        if (legal) chk("done_timing", k, b_k + 1);
        got_done = 1;
        break;
      end
      if (m_axi_awvalid && m_axi_awready) aw_done = 1;
    end
    wr_start = 1'b0;
    wr_data_vld = 1'b0;
    m_axi_bvalid = 1'b0;
    if (v.rst_at >= 0) begin
      chk("rst_beats", nbeats, v.rst_at);
      chk("rst_got_done", got_done, 0);
    end else begin
      chk("got_done", got_done, 1);
      chk("beats", nbeats, v.exp_beats);
      chk("aw_count", aw_hs, legal ? 1 : 0);
    end
  endtask

  vec_t vt[11];
  vec_t rv;

  initial begin
    vt[0]  = '{64'h1000, 9'd1,   2'b00, 0, 0, 0, -1, 0, 1};
    vt[1]  = '{64'h2000, 9'd16,  2'b00, 0, 1, 0, -1, 0, 16};
    vt[2]  = '{64'h3000, 9'd256, 2'b00, 5, 0, 0, -1, 0, 256};
    vt[3]  = '{64'h4000, 9'd4,   2'b10, 0, 0, 0, -1, 1, 4};
    vt[4]  = '{64'h5000, 9'd0,   2'b00, 0, 0, 0, -1, 1, 0};
    vt[5]  = '{64'h6000, 9'd300, 2'b00, 0, 0, 0, -1, 1, 0};
    vt[6]  = '{64'h7000, 9'd16,  2'b00, 0, 0, 1, -1, 0, 16};
    vt[7]  = '{64'h8000, 9'd16,  2'b00, 0, 0, 0, 5,  0, 5};
    vt[8]  = '{64'h9000, 9'd16,  2'b00, 2, 1, 0, -1, 0, 16};
    vt[9]  = '{64'hA000, 9'd2,   2'b11, 1, 0, 0, -1, 1, 2};
    vt[10] = '{64'hB000, 9'd3,   2'b01, 0, 1, 0, -1, 0, 3};
    repeat (2) @(negedge clk_sys);
    #1;
    chk("reset_busy", wr_busy, 0);
    chk("reset_done", wr_done, 0);
    chk("reset_awvalid", m_axi_awvalid, 0);
    chk("reset_awaddr", m_axi_awaddr, 0);
    chk("reset_awlen", m_axi_awlen, 0);
    chk("reset_bready", m_axi_bready, 0);
    chk("awsize", m_axi_awsize, 2);
    chk("awburst", m_axi_awburst, 1);
    chk("awcache", m_axi_awcache, 3);
    chk("wstrb", m_axi_wstrb, 4'hF);
    chk("aw_misc", {m_axi_awlock, m_axi_awprot, m_axi_awqos}, 0);
    rst_sys = 1'b0;
    for (int i = 0; i < 11; i++) run_txn(vt[i]);
    for (int i = 0; i < 25; i++) begin
      rv.addr   = {32'h0, $urandom} & 64'hFFFF_F000;
      rv.len    = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 9'd0 : 9'($urandom_range(257, 511)))
                                               : 9'($urandom_range(1, 48));
      rv.bresp  = 2'($urandom_range(0, 3));
      rv.aw_dly = $urandom_range(0, 6);
      rv.rnd    = 1;
      rv.poke   = 0;
      rv.rst_at = -1;
      rv.exp_err   = (rv.len == 0) || (rv.len > 256) || rv.bresp[1];
      rv.exp_beats = ((rv.len == 0) || (rv.len > 256)) ? 0 : int'(rv.len);
      run_txn(rv);
    end
    @(negedge clk_sys);
    #1;
    chk("final_idle", wr_busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
